// File: rtl/vending_change_payout.sv
// vending_change_payout: greedy two-hopper coin payout (₹2 then ₹1) with
// request/ack handshake, empty-hopper fallback and ack timeout.
module vending_change_payout #(
   parameter int AMT_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             empty2,
   input  logic             empty1,
   input  logic             hopper_ack,
   output logic             coin2,
   output logic             coin1,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [AMT_W-1:0] paid
);
   typedef enum logic [1:0] {IDLE, SEL, WAIT} state_t;
   localparam logic [7:0]       TMAX = 8'(TIMEOUT - 1);
   localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);
   localparam logic [AMT_W-1:0] TWO  = AMT_W'(2);
   state_t           state, state_n;
   logic [AMT_W-1:0] remaining, remaining_n, paid_n, coin_val;
   logic [7:0]       timer, timer_n;
   logic             coin2_n, coin1_n, busy_n, done_n, err_n;
   assign coin_val = coin2 ? TWO : ONE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         remaining <= '0;
         timer     <= '0;
         paid      <= '0;
         coin2     <= 1'b0;
         coin1     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         timer     <= timer_n;
         paid      <= paid_n;
         coin2     <= coin2_n;
         coin1     <= coin1_n;
         busy      <= busy_n;
         done      <= done_n;
         err       <= err_n;
      end
   end
   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      timer_n     = timer;
      paid_n      = paid;
      coin2_n     = coin2;
      coin1_n     = coin1;
      busy_n      = busy;
      done_n      = 1'b0;
      err_n       = 1'b0;
      case (state)
         IDLE: if (req) begin
            paid_n = '0;
            if (amount == '0) begin
               done_n = 1'b1;
            end else begin
               remaining_n = amount;
               busy_n      = 1'b1;
               state_n     = SEL;
            end
         end
         SEL: begin
            timer_n = '0;
            // a ₹2 shortfall falls back to ₹1 coins when the ₹2 hopper is empty
            if (remaining >= TWO && !empty2) begin
               coin2_n = 1'b1;
               state_n = WAIT;
            end else if (remaining != '0 && !empty1) begin
               coin1_n = 1'b1;
               state_n = WAIT;
            end else begin
               err_n       = 1'b1;
               busy_n      = 1'b0;
               remaining_n = '0;
               state_n     = IDLE;
            end
         end
         WAIT: begin
            if (hopper_ack) begin
               coin2_n     = 1'b0;
               coin1_n     = 1'b0;
               timer_n     = '0;
               remaining_n = remaining - coin_val;
               paid_n      = paid + coin_val;
               if (remaining == coin_val) begin
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end else begin
                  state_n = SEL;
               end
            end else if (timer == TMAX) begin
               coin2_n     = 1'b0;
               coin1_n     = 1'b0;
               timer_n     = '0;
               err_n       = 1'b1;
               busy_n      = 1'b0;
               remaining_n = '0;
               state_n     = IDLE;
            end else begin
               timer_n = timer + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
